seg7_scan: RTL and testbench

Time-multiplexed 7-segment display driver that consumes the eight BCD digit outputs of the seconds counter, cnt_d0 (least significant) through cnt_d7. It scans one digit at a time at a programmable refresh rate, drives the shared segment bus and a one-hot digit-select bus, and latches a coherent snapshot of all eight digits once per frame so a counter carry never tears across the display.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan.sv | 100 ++++++++++
 tb/tb_seg7_scan.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and the BCD-to-segment function for the
// seg7 display driver.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0]                  bcd_t;
  typedef bcd_t [NUM_DIGITS-1:0]       frame_t;

  // Active-high segments, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic [6:0] bcd2seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;  // non-BCD codes show a dash
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational BCD digit to 7-segment pattern decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = bcd2seg(i_bcd);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit 7-segment scanner with a per-frame input snapshot.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cnt_d0,
  input  logic [3:0] cnt_d1,
  input  logic [3:0] cnt_d2,
  input  logic [3:0] cnt_d3,
  input  logic [3:0] cnt_d4,
  input  logic [3:0] cnt_d5,
  input  logic [3:0] cnt_d6,
  input  logic [3:0] cnt_d7,
  output logic [6:0] seg,
  output logic [7:0] dig_sel,
  output logic       frame_start
);

  localparam int             PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_pre_cnt;
  logic [2:0]    r_idx;
  logic          r_first_done;
  frame_t        r_snap;
  logic [6:0]    r_seg;
  logic [7:0]    r_dig_sel;
  logic          r_frame_start;

  logic          w_tick;
  logic [2:0]    w_idx_next;
  logic          w_new_frame;
  frame_t        w_in;
  frame_t        w_digits;
  logic [6:0]    w_dec_seg;
  logic          w_blank;
  logic [6:0]    w_seg_next;

  assign w_in        = {cnt_d7, cnt_d6, cnt_d5, cnt_d4, cnt_d3, cnt_d2, cnt_d1, cnt_d0};
  assign w_tick      = (r_pre_cnt == PRE_MAX);
  assign w_idx_next  = r_first_done ? r_idx + 3'd1 : 3'd0;
  assign w_new_frame = w_tick && (w_idx_next == 3'd0);

  // The digit-0 slot is decoded from the snapshot being taken on this very tick.
  assign w_digits = w_new_frame ? w_in : r_snap;

  seg7_decode u_decode (
    .i_bcd (w_digits[w_idx_next]),
    .o_seg (w_dec_seg)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic [2:0] w_top;

  always_comb begin
    w_top = 3'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (w_digits[i] != 4'd0) w_top = 3'(i);
    end
  end

  assign w_blank = (w_idx_next > w_top);
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg_next = w_blank ? SEG_OFF : w_dec_seg;

  // NOTE: the snapshot is a small flop bank, not a RAM, so it is reset with the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre_cnt     <= '0;
      r_idx         <= 3'd0;
      r_first_done  <= 1'b0;
      r_snap        <= '0;
      r_seg         <= SEG_OFF;
      r_dig_sel     <= 8'hFF;
      r_frame_start <= 1'b0;
    end else begin
      r_pre_cnt     <= w_tick ? '0 : r_pre_cnt + PW'(1);
      r_frame_start <= w_new_frame;
      if (w_new_frame) r_snap <= w_in;
      if (w_tick) begin
        r_idx        <= w_idx_next;
        r_first_done <= 1'b1;
        r_seg        <= w_seg_next;
        r_dig_sel    <= ~(8'b1 << w_idx_next);
      end
    end
  end

  assign seg         = r_seg;
  assign dig_sel     = r_dig_sel;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: randomized digits against a slot/frame
// timing model. Honours SEG7_LZ_BLANK_EN the same way the design does.
module tb_seg7_scan;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 8 * CLK_DIV;

  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d [8];
  logic [6:0] seg;
  logic [7:0] dig_sel;
  logic       frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .cnt_d0      (d[0]),
    .cnt_d1      (d[1]),
    .cnt_d2      (d[2]),
    .cnt_d3      (d[3]),
    .cnt_d4      (d[4]),
    .cnt_d5      (d[5]),
    .cnt_d6      (d[6]),
    .cnt_d7      (d[7]),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .frame_start (frame_start)
  );

  // Reference model: e counts rising edges since reset release; the display
  // switches slots every CLK_DIV edges starting at edge CLK_DIV, and the
  // inputs are frozen at the start of every 8-slot frame.
  int         e = 0;
  logic [3:0] m_snap [8];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e = 0;
      foreach (m_snap[i]) m_snap[i] = 4'd0;
    end else begin
      e = e + 1;
      if (e >= CLK_DIV && (e - CLK_DIV) % FRAME == 0)
        foreach (m_snap[i]) m_snap[i] = d[i];
    end
  end

  function automatic void expect_now(output logic [7:0] xs, output logic [6:0] xg, output logic xf);
    int slot, dg, top;
    top = 0;
    for (int i = 1; i < 8; i++) if (m_snap[i] != 4'd0) top = i;
    if (reset || e < CLK_DIV) begin
      xs = 8'hFF; xg = 7'h00; xf = 1'b0;
    end else begin
      slot = (e - CLK_DIV) / CLK_DIV;
      dg   = slot % 8;
      xs   = 8'hFF ^ (8'h01 << dg);
      xg   = PAT[m_snap[dg]];
`ifdef SEG7_LZ_BLANK_EN
      if (dg > top) xg = 7'h00;
`endif
      xf   = ((e - CLK_DIV) % CLK_DIV == 0) && (dg == 0);
    end
  endfunction

  task automatic set_digits(input logic [31:0] v);
    for (int i = 0; i < 8; i++) d[i] = v[4*i +: 4];
  endtask

  task automatic test_reset();
    set_digits(32'h8765_4321);
    repeat (2) @(negedge clk);
    n_tests++;
    if (dig_sel !== 8'hFF || seg !== 7'h00 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: sel=%h seg=%h fs=%b, want sel=ff seg=00 fs=0", dig_sel, seg, frame_start);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < CLK_DIV; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if (dig_sel !== 8'hFF || seg !== 7'h00 || frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: sel=%h seg=%h fs=%b, want sel=ff seg=00 fs=0", i, dig_sel, seg, frame_start);
      end
    end
    @(negedge clk);
    n_tests++;
    if (dig_sel !== 8'hFE || seg !== 7'h06 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL first_slot: sel=%h seg=%h fs=%b, want sel=fe seg=06 fs=1", dig_sel, seg, frame_start);
    end
    @(negedge clk);
    n_tests++;
    if (dig_sel !== 8'hFE || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_pulse: sel=%h fs=%b, want sel=fe fs=0", dig_sel, frame_start);
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] xs; logic [6:0] xg; logic xf;
    set_digits(32'h8765_4321);
    for (int c = 0; c < 2 * FRAME + 3; c++) begin
      @(negedge clk);
      expect_now(xs, xg, xf);
      n_tests++;
      if (dig_sel !== xs || seg !== xg || frame_start !== xf) begin
        n_fail++;
        $display("FAIL scan_order c%0d: sel=%h seg=%h fs=%b, want sel=%h seg=%h fs=%b",
                 c, dig_sel, seg, frame_start, xs, xg, xf);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] xs; logic [6:0] xg; logic xf;
    bit seen3 = 0;
    bit seen0 = 0;
    set_digits(32'h8765_4321);
    for (int c = 0; c < 2 * FRAME && !seen3; c++) begin
      @(negedge clk);
      expect_now(xs, xg, xf);
      if (xs == 8'hF7) seen3 = 1;
    end
    n_tests++;
    if (!seen3) begin
      n_fail++;
      $display("FAIL snap_wait: digit-3 slot not reached, sel=%h", dig_sel);
    end
    d[0] = 4'd9;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      expect_now(xs, xg, xf);
      n_tests++;
      if (dig_sel !== xs || seg !== xg || frame_start !== xf) begin
        n_fail++;
        $display("FAIL snapshot c%0d: sel=%h seg=%h fs=%b, want sel=%h seg=%h fs=%b",
                 c, dig_sel, seg, frame_start, xs, xg, xf);
      end
      if (xs == 8'hFE && !seen0) begin
        seen0 = 1;
        n_tests++;
        if (seg !== 7'h6F) begin
          n_fail++;
          $display("FAIL snap_new_frame: seg=%h, want 6f", seg);
        end
      end
    end
  endtask

  task automatic test_dash();
    logic [7:0] xs; logic [6:0] xg; logic xf;
    set_digits(32'h8765_4A21);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      expect_now(xs, xg, xf);
      n_tests++;
      if (dig_sel !== xs || seg !== xg || frame_start !== xf) begin
        n_fail++;
        $display("FAIL dash c%0d: sel=%h seg=%h fs=%b, want sel=%h seg=%h fs=%b",
                 c, dig_sel, seg, frame_start, xs, xg, xf);
      end
      if (xs == 8'hFB && m_snap[2] == 4'hA) begin
        n_tests++;
        if (seg !== 7'h40) begin
          n_fail++;
          $display("FAIL dash_pattern: seg=%h, want 40", seg);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] xs; logic [6:0] xg; logic xf;
    for (int p = 0; p < 2; p++) begin
      set_digits(p == 0 ? 32'h0000_0305 : 32'h0000_0000);
      for (int c = 0; c < 2 * FRAME; c++) begin
        @(negedge clk);
        expect_now(xs, xg, xf);
        n_tests++;
        if (dig_sel !== xs || seg !== xg || frame_start !== xf) begin
          n_fail++;
          $display("FAIL lz p%0d c%0d: sel=%h seg=%h fs=%b, want sel=%h seg=%h fs=%b",
                   p, c, dig_sel, seg, frame_start, xs, xg, xf);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] xs; logic [6:0] xg; logic xf;
    for (int c = 0; c < 10 * FRAME; c++) begin
      @(negedge clk);
      expect_now(xs, xg, xf);
      n_tests++;
      if (dig_sel !== xs || seg !== xg || frame_start !== xf) begin
        n_fail++;
        $display("FAIL random c%0d: sel=%h seg=%h fs=%b, want sel=%h seg=%h fs=%b",
                 c, dig_sel, seg, frame_start, xs, xg, xf);
      end
      if ($urandom_range(0, 2) == 0) d[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        int k = $urandom_range(1, 8);
        for (int i = 8 - k; i < 8; i++) d[i] = 4'd0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] xs; logic [6:0] xg; logic xf;
    bit seen5 = 0;
    set_digits(32'h1234_5678);
    for (int c = 0; c < 2 * FRAME && !seen5; c++) begin
      @(negedge clk);
      expect_now(xs, xg, xf);
      if (xs == 8'hDF) seen5 = 1;
    end
    n_tests++;
    if (!seen5) begin
      n_fail++;
      $display("FAIL mid_wait: digit-5 slot not reached, sel=%h", dig_sel);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (dig_sel !== 8'hFF || seg !== 7'h00 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: sel=%h seg=%h fs=%b, want sel=ff seg=00 fs=0", dig_sel, seg, frame_start);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      expect_now(xs, xg, xf);
      n_tests++;
      if (dig_sel !== xs || seg !== xg || frame_start !== xf) begin
        n_fail++;
        $display("FAIL restart c%0d: sel=%h seg=%h fs=%b, want sel=%h seg=%h fs=%b",
                 c, dig_sel, seg, frame_start, xs, xg, xf);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_order();
    test_snapshot();
    test_dash();
    test_leading_zero();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
